button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, synchronized input mismatch duration required to accept a level change (20 ms at 50 MHz); legal range >=2.
REQ-002 Parameter REPEAT_DELAY, default 25000000, cycles an increment button must stay held after its first pulse before auto-repeat starts; legal range >=1.
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between auto-repeat pulses; legal range >=1.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 btn_raw  input  5  asynchronous raw pushbuttons, active-high: [0] start, [1] stop, [2] delete, [3] incrementSeconds, [4] incrementMinutes.
REQ-007 start  output  1  one-cycle command pulse.
REQ-008 stop  output  1  one-cycle command pulse.
REQ-009 delete  output  1  one-cycle command pulse.
REQ-010 incrementSeconds  output  1  one-cycle pulse, auto-repeating while held.
REQ-011 incrementMinutes  output  1  one-cycle pulse, auto-repeating while held.
REQ-012 btn_level  output  5  debounced stable level per button, same bit order as btn_raw.

Function
REQ-013 Each btn_raw bit SHALL pass through a private 2-flop synchronizer before any other use.
REQ-014 Each button SHALL have its own debounce counter and stable register; the counter clears whenever the synchronized value equals the stable value.
REQ-015 While the synchronized value differs from the stable value, the counter SHALL increment each cycle; on the edge where it would reach DEBOUNCE_CYCLES, the stable value SHALL take the synchronized value and the counter SHALL clear.
REQ-016 A mismatch lasting fewer than DEBOUNCE_CYCLES cycles SHALL leave the stable value unchanged and produce no pulse (bounce rejection).
REQ-017 btn_level SHALL equal the stable registers directly.
REQ-018 A 0->1 transition of a stable register SHALL produce a registered output pulse of exactly one cycle in the following cycle; latency from the raw-sampling edge to the pulse-high cycle = DEBOUNCE_CYCLES+3 edges.
REQ-019 1->0 stable transitions SHALL produce no pulse.
REQ-020 Command arbitration: if more than one of start/stop/delete would pulse in the same cycle, only the highest priority SHALL be emitted (delete > stop > start); lower-priority pulses are dropped, not deferred.
REQ-021 Increment buttons SHALL be independent of each other and of the command buttons; simultaneous pulses on both increments are permitted.
REQ-022 Per increment button, a hold counter SHALL start at the initial pulse; while the stable level stays 1, a repeat pulse SHALL occur REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles.
REQ-023 Stable level falling to 0 SHALL clear the hold counter in the same edge; no repeat pulse is emitted in or after that cycle.
REQ-024 Hold counters SHALL saturate-free wrap only through REPEAT_PERIOD reload; width sized to max(REPEAT_DELAY, REPEAT_PERIOD).
REQ-025 Command buttons (start, stop, delete) SHALL never auto-repeat.

Reset
REQ-026 On reset, synchronizers, stable registers, debounce counters, hold counters and all outputs SHALL go to 0 on the same edge; all outputs read 0 in the cycle after the reset edge.
REQ-027 Reset asserted mid-debounce or mid-repeat SHALL abort the operation with no pulse emitted.
REQ-028 A button held high across reset release SHALL be treated as a fresh press: pulse after DEBOUNCE_CYCLES+3 edges.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-029 Clean press: btn_raw[0] 0->1 sampled at edge 0, held -> btn_level[0]=1 after edge 6, start=1 only in the cycle after edge 7, no further pulses.
REQ-030 Bounce: btn_raw[1] high for 3 cycles, low 2, high 3, then low -> stop never asserted, btn_level[1] stays 0.
REQ-031 Auto-repeat: btn_raw[3] held 40 cycles -> incrementSeconds pulses after edges 7, 17, 22, 27, 32, 37, 42; pulse count 7; none after release is debounced.
REQ-032 Arbitration: btn_raw[0] and btn_raw[2] rise same edge -> delete pulses once, start never pulses.
REQ-033 Reset mid-operation: btn_raw[4] held, reset at edge 5 for 1 cycle -> no pulse before edge 13; incrementMinutes pulse after edge 13 (fresh press timing).

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Conditions five raw pushbuttons into clean one-cycle command pulses.
// Each raw input is synchronized (2 flops), debounced with its own counter and
// stable register, and rising edges of the stable level become registered
// pulses. start/stop/delete are mutually exclusive (delete > stop > start) and
// never repeat. The two increment buttons auto-repeat while held.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high
//   btn_raw[4:0]     in   raw buttons: [0] start, [1] stop, [2] delete,
//                         [3] incrementSeconds, [4] incrementMinutes
//   start            out  one-cycle command pulse
//   stop             out  one-cycle command pulse
//   delete           out  one-cycle command pulse
//   incrementSeconds out  one-cycle pulse, auto-repeats while held
//   incrementMinutes out  one-cycle pulse, auto-repeats while held
//   btn_level[4:0]   out  debounced stable level, same bit order as btn_raw
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn_raw,
    output logic       start,
    output logic       stop,
    output logic       delete,
    output logic       incrementSeconds,
    output logic       incrementMinutes,
    output logic [4:0] btn_level
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

    logic [4:0]    sync1, sync2;
    logic [4:0]    stable, stable_q, stable_nxt, rise;
    logic [DW-1:0] db_cnt [5];
    logic [HW-1:0] hold_cnt [2];
    logic [HW-1:0] hold_nxt [2];
    logic [1:0]    rep_fire;

    // Two-flop synchronizer per button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // The stable value flips only once the counter has already accumulated
    // DEBOUNCE_CYCLES mismatching cycles and the mismatch is still present.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 5; i++) begin
            if (sync2[i] != stable[i] && db_cnt[i] == DW'(DEBOUNCE_CYCLES))
                stable_nxt[i] = sync2[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable   <= '0;
            stable_q <= '0;
            for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            stable   <= stable_nxt;
            stable_q <= stable;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i] || db_cnt[i] == DW'(DEBOUNCE_CYCLES))
                    db_cnt[i] <= '0;
                else
                    db_cnt[i] <= db_cnt[i] + 1'b1;
            end
        end
    end

    assign rise      = stable & ~stable_q;
    assign btn_level = stable;

    // Hold counters for the increment buttons (bits 3 and 4). Loaded on the
    // initial press pulse, then count down; reaching zero while still held
    // fires a repeat and reloads with the repeat period. A release decided on
    // this edge (stable_nxt low) clears the counter and suppresses any repeat.
    always_comb begin
        for (int j = 0; j < 2; j++) begin
            rep_fire[j] = 1'b0;
            hold_nxt[j] = hold_cnt[j];
            if (!stable_nxt[3+j]) begin
                hold_nxt[j] = '0;
            end else if (rise[3+j]) begin
                hold_nxt[j] = HW'(REPEAT_DELAY - 1);
            end else if (stable_q[3+j]) begin
                if (hold_cnt[j] == '0) begin
                    rep_fire[j] = 1'b1;
                    hold_nxt[j] = HW'(REPEAT_PERIOD - 1);
                end else begin
                    hold_nxt[j] = hold_cnt[j] - 1'b1;
                end
            end
        end
    end

    // Registered pulses. Lower-priority commands are dropped when a higher
    // one rises in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt[0]      <= '0;
            hold_cnt[1]      <= '0;
            start            <= 1'b0;
            stop             <= 1'b0;
            delete           <= 1'b0;
            incrementSeconds <= 1'b0;
            incrementMinutes <= 1'b0;
        end else begin
            hold_cnt[0]      <= hold_nxt[0];
            hold_cnt[1]      <= hold_nxt[1];
            delete           <= rise[2];
            stop             <= rise[1] & ~rise[2];
            start            <= rise[0] & ~rise[1] & ~rise[2];
            incrementSeconds <= rise[3] | rep_fire[0];
            incrementMinutes <= rise[4] | rep_fire[1];
        end
    end

endmodule
